// File: rtl/circular_rotate_core.sv
// circular_rotate_core: combinational rotate-by-constant of an N-bit word.
// Produces left/right rotations two ways (bit-slice concatenation and
// ORed logical shifts) so the enclosing stage can cross-check them.
module circular_rotate_core #(
  parameter int unsigned N = 8,
  parameter int unsigned S = 3
) (
  input  logic [N-1:0] in_data,
  output logic [N-1:0] rotl_slice,
  output logic [N-1:0] rotl_or,
  output logic [N-1:0] rotr_slice,
  output logic [N-1:0] rotr_or
);

  // Effective distance: rotating by a multiple of N is the identity.
  localparam int unsigned SE  = S % N;
  localparam int unsigned SEC = N - SE;

  // Shift form. Operands stay N bits wide, so bits pushed past either end
  // are dropped; with SE == 0 the complementary shift is by N and yields 0.
  assign rotl_or = (in_data << SE) | (in_data >> SEC);
  assign rotr_or = (in_data >> SE) | (in_data << SEC);

  // Slice form. SE == 0 would need zero-width slices, so it is a pass-through.
  generate
    if (SE == 0) begin : g_identity
      assign rotl_slice = in_data;
      assign rotr_slice = in_data;
    end else begin : g_slices
      assign rotl_slice = {in_data[N-SE-1:0], in_data[N-1:N-SE]};
      assign rotr_slice = {in_data[SE-1:0],   in_data[N-1:SE]};
    end
  endgenerate

endmodule

// File: rtl/circular_shift_unit.sv
// circular_shift_unit: one-cycle pipeline stage that registers constant
// distance rotations of its input and flags disagreement between the two
// independent constructions of each rotation.
module circular_shift_unit #(
  parameter int unsigned N = 8,
  parameter int unsigned S = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  output logic [N-1:0] rotl_slice,
  output logic [N-1:0] rotl_or,
  output logic [N-1:0] rotr_slice,
  output logic [N-1:0] rotr_or,
  output logic         mismatch
);

  logic [N-1:0] rotl_slice_s;
  logic [N-1:0] rotl_or_s;
  logic [N-1:0] rotr_slice_s;
  logic [N-1:0] rotr_or_s;
  logic         mismatch_s;

  logic         out_valid_r;
  logic [N-1:0] rotl_slice_r;
  logic [N-1:0] rotl_or_r;
  logic [N-1:0] rotr_slice_r;
  logic [N-1:0] rotr_or_r;
  logic         mismatch_r;

  circular_rotate_core #(
    .N (N),
    .S (S)
  ) u_core (
    .in_data    (in_data),
    .rotl_slice (rotl_slice_s),
    .rotl_or    (rotl_or_s),
    .rotr_slice (rotr_slice_s),
    .rotr_or    (rotr_or_s)
  );

  // Self-check: the two constructions of each rotation must agree.
  always_comb begin
    mismatch_s = 1'b0;
    if ((rotl_slice_s != rotl_or_s) || (rotr_slice_s != rotr_or_s)) begin
      mismatch_s = 1'b1;
    end else begin
      mismatch_s = 1'b0;
    end
  end

  // Pipeline register: load on valid input, hold results otherwise; reset wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r  <= 1'b0;
      rotl_slice_r <= '0;
      rotl_or_r    <= '0;
      rotr_slice_r <= '0;
      rotr_or_r    <= '0;
      mismatch_r   <= 1'b0;
    end else if (in_valid) begin
      out_valid_r  <= 1'b1;
      rotl_slice_r <= rotl_slice_s;
      rotl_or_r    <= rotl_or_s;
      rotr_slice_r <= rotr_slice_s;
      rotr_or_r    <= rotr_or_s;
      mismatch_r   <= mismatch_s;
    end else begin
      out_valid_r  <= 1'b0;
    end
  end

  assign out_valid  = out_valid_r;
  assign rotl_slice = rotl_slice_r;
  assign rotl_or    = rotl_or_r;
  assign rotr_slice = rotr_slice_r;
  assign rotr_or    = rotr_or_r;
  assign mismatch   = mismatch_r;

endmodule

// File: tb/tb_circular_shift_unit.sv
// tb_circular_shift_unit: directed plus randomized checks of the rotate stage
// (N=8, S=3) and of a sweep of extra instances with S in {0,1,7,8,11}.
module tb_circular_shift_unit;

  localparam int unsigned N = 8;
  localparam int NSW = 5;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [N-1:0] in_data;

  logic         out_valid;
  logic [N-1:0] rotl_slice;
  logic [N-1:0] rotl_or;
  logic [N-1:0] rotr_slice;
  logic [N-1:0] rotr_or;
  logic         mismatch;

  logic         sw_valid [NSW];
  logic [N-1:0] sw_l_sl  [NSW];
  logic [N-1:0] sw_l_or  [NSW];
  logic [N-1:0] sw_r_sl  [NSW];
  logic [N-1:0] sw_r_or  [NSW];
  logic         sw_mis   [NSW];

  int s_tab [NSW] = '{0, 1, 7, 8, 11};

  int passed = 0;
  int total  = 0;

  circular_shift_unit #(.N(N), .S(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .rotl_slice (rotl_slice),
    .rotl_or    (rotl_or),
    .rotr_slice (rotr_slice),
    .rotr_or    (rotr_or),
    .mismatch   (mismatch)
  );

  generate
    for (genvar g = 0; g < NSW; g++) begin : g_sweep
      localparam int unsigned SV = (g == 0) ? 0 : (g == 1) ? 1 : (g == 2) ? 7 : (g == 3) ? 8 : 11;
      circular_shift_unit #(.N(N), .S(SV)) dut_sw (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (sw_valid[g]),
        .rotl_slice (sw_l_sl[g]),
        .rotl_or    (sw_l_or[g]),
        .rotr_slice (sw_r_sl[g]),
        .rotr_or    (sw_r_or[g]),
        .mismatch   (sw_mis[g])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference rotations straight from the bit-position definitions.
  function automatic logic [N-1:0] ref_rotl(input logic [N-1:0] d, input int s);
    logic [N-1:0] r;
    int se;
    se = s % N;
    r = '0;
    for (int i = 0; i < N; i++) r[(i + se) % N] = d[i];
    return r;
  endfunction

  function automatic logic [N-1:0] ref_rotr(input logic [N-1:0] d, input int s);
    logic [N-1:0] r;
    int se;
    se = s % N;
    r = '0;
    for (int i = 0; i < N; i++) r[i] = d[(i + se) % N];
    return r;
  endfunction

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Compare every output of the main instance.
  task automatic check_main(input string tag, input logic v, input logic [N-1:0] l, input logic [N-1:0] r);
    check({tag, " out_valid"},  {7'd0, out_valid}, {7'd0, v});
    check({tag, " rotl_slice"}, rotl_slice, l);
    check({tag, " rotl_or"},    rotl_or, l);
    check({tag, " rotr_slice"}, rotr_slice, r);
    check({tag, " rotr_or"},    rotr_or, r);
    check({tag, " mismatch"},   {7'd0, mismatch}, 8'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_check(input string tag, input logic [N-1:0] d, input logic [N-1:0] l, input logic [N-1:0] r);
    in_data  = d;
    in_valid = 1'b1;
    tick();
    check_main(tag, 1'b1, l, r);
  endtask

  initial begin
    logic [N-1:0] d;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // 1: reset, then the first transaction
    tick();
    tick();
    check_main("reset", 1'b0, 8'h00, 8'h00);
    rst = 1'b0;
    send_check("first", 8'b10110101, 8'b10101101, 8'b10110110);

    // 2: walking one
    send_check("walk80", 8'b10000000, 8'b00000100, 8'b00010000);
    send_check("walk04", 8'b00000100, 8'b00100000, 8'b10000000);
    send_check("walk20", 8'b00100000, 8'b00000001, 8'b00000100);

    // 3: back-to-back stream
    send_check("strm70", 8'b01110000, 8'b10000011, 8'b00001110);
    send_check("strm26", 8'b00100110, 8'b00110001, 8'b11000100);
    send_check("strmd1", 8'b11010001, 8'b10001110, 8'b00111010);
    send_check("strmff", 8'b11111111, 8'b11111111, 8'b11111111);
    send_check("strm00", 8'b00000000, 8'b00000000, 8'b00000000);

    // 4: valid gating, results hold
    send_check("gate_ld", 8'b01100110, 8'b00110011, 8'b11001100);
    in_valid = 1'b0;
    in_data  = 8'b11110000;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_main("gate_hold", 1'b0, 8'b00110011, 8'b11001100);
    end

    // 5: reset mid-stream dominates in_valid
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'b11110000;
    tick();
    check_main("rst_mid", 1'b0, 8'h00, 8'h00);
    rst = 1'b0;
    send_check("rst_after", 8'b11110000, 8'b10000111, 8'b00011110);

    // 6: randomized sweep across distances, checked against the reference
    for (int t = 0; t < 24; t++) begin
      d        = 8'($urandom_range(0, 255));
      in_data  = d;
      in_valid = 1'b1;
      tick();
      check_main("rand_s3", 1'b1, ref_rotl(d, 3), ref_rotr(d, 3));
      for (int k = 0; k < NSW; k++) begin
        check($sformatf("sw%0d valid", s_tab[k]),   {7'd0, sw_valid[k]}, 8'd1);
        check($sformatf("sw%0d l_slice", s_tab[k]), sw_l_sl[k], ref_rotl(d, s_tab[k]));
        check($sformatf("sw%0d l_or", s_tab[k]),    sw_l_or[k], ref_rotl(d, s_tab[k]));
        check($sformatf("sw%0d r_slice", s_tab[k]), sw_r_sl[k], ref_rotr(d, s_tab[k]));
        check($sformatf("sw%0d r_or", s_tab[k]),    sw_r_or[k], ref_rotr(d, s_tab[k]));
        check($sformatf("sw%0d mismatch", s_tab[k]), {7'd0, sw_mis[k]}, 8'd0);
      end
    end

    in_valid = 1'b0;
    tick();
    check("final out_valid", {7'd0, out_valid}, 8'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/circular_shift_unit.md
Name: circular_shift_unit

Overview:
- Registered constant-distance circular (rotate) shifter for an N-bit word, S positions left and right.
- Computes each rotation two ways, bit-slice concatenation and ORing two logical shifts, and registers all results.
- Flags any disagreement between the two methods as a self-check.
- Sits in the arithmetic datapath as a one-cycle pipeline stage.

Parameters:
- N, 8, data width in bits; N >= 2.
- S, 3, rotate distance in bits; any value >= 0. Effective distance SE = S mod N.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data is valid this cycle.
- in_data  input  N  word to rotate.
- out_valid  output  1  output words are valid this cycle.
- rotl_slice  output  N  left rotate by SE, built from bit slices and concatenation.
- rotl_or  output  N  left rotate by SE, built as (in_data << SE) | (in_data >> (N-SE)).
- rotr_slice  output  N  right rotate by SE, built from bit slices and concatenation.
- rotr_or  output  N  right rotate by SE, built as (in_data >> SE) | (in_data << (N-SE)).
- mismatch  output  1  set when the two left results differ or the two right results differ.

Behaviour:
- Rotation definitions:
  - Left: result[(i+SE) mod N] = in_data[i] for every i; MSBs wrap to the LSB end.
  - Right: result[i] = in_data[(i+SE) mod N]; LSBs wrap to the MSB end.
- Slice form:
  - Left = {in_data[N-SE-1:0], in_data[N-1:N-SE]}.
  - Right = {in_data[SE-1:0], in_data[N-1:SE]}.
- Shift operands are N bits wide; no bits are carried outside N.
- SE == 0, including S == N and multiples of N: every output equals in_data. The slice form must use a generate branch so no zero-width slice appears.
- Rotation logic is purely combinational; results are registered.
- Latency is exactly 1 cycle from in_valid to out_valid.
- In a cycle with in_valid=1 and rst=0, at the next edge:
  - all four result registers load their rotations of in_data;
  - out_valid <= 1;
  - mismatch <= (rotl_slice_c != rotl_or_c) || (rotr_slice_c != rotr_or_c).
- In a cycle with in_valid=0 and rst=0: out_valid <= 0 at the next edge; results and mismatch hold their previous values.
- Back-to-back in_valid is supported: one result per cycle, no stalls, no backpressure.
- Reset: with rst=1 at an edge, out_valid, all four results and mismatch become 0. Reset dominates in_valid. A transaction in flight during reset is discarded.
- mismatch must always be 0 in a correct implementation; it exists for checking only.
- All-zero and all-one inputs map to themselves under both rotations.

Decomposition:
- No shared package; N and S are plain module parameters.
- One sub-module, circular_rotate_core (parameters N, S): combinational, input N bits.
  - Produces the four rotation words: left/right × slice/OR.
  - Contains the SE computation and the SE == 0 generate guard.
- The top level holds the registers, valid pipeline and mismatch compare.

Test Plan:
1. Reset then N=8, S=3: rst high 2 cycles -> out_valid=0, all results 0x00, mismatch=0. Then in_data=8'b10110101, in_valid=1 -> next cycle out_valid=1, rotl_* = 8'b10101101, rotr_* = 8'b10110110, mismatch=0.
2. Walking one: in_data=8'b10000000 -> L 8'b00000100, R 8'b00010000. in_data=8'b00000100 -> L 8'b00100000, R 8'b10000000. in_data=8'b00100000 -> L 8'b00000001, R 8'b00000100.
3. Back-to-back streaming, one per cycle, each checked 1 cycle later:
   - 8'b01110000 -> L 8'b10000011, R 8'b00001110.
   - 8'b00100110 -> L 8'b00110001, R 8'b11000100.
   - 8'b11010001 -> L 8'b10001110, R 8'b00111010.
   - 8'b11111111 -> L/R 8'b11111111.
   - 8'b00000000 -> L/R 8'b00000000.
4. Valid gating: in_valid=0 for 3 cycles after input 8'b01100110 -> out_valid drops to 0; results hold L 8'b00110011, R 8'b11001100.
5. Reset mid-stream: assert rst while in_valid=1 with 8'b11110000 -> next cycle out_valid=0, results 0. After release, the same input yields L 8'b10000111, R 8'b00011110.
6. Parameter sweep N=8, S in {0,1,7,8,11}, random inputs -> results match the mod-N reference rotation. S=0 and S=8 give identity; S=11 behaves as S=3. mismatch stays 0 throughout.
